// File: rtl/next_pc_unit.sv
// Next-PC generation for a MIPS-style fetch stage with a small return-address stack.
//
// Each cycle this block picks the next fetch address and registers it into pc.
// The candidates, in priority order, are:
//   - a J/JAL target
//   - a taken BEQ or BNE target
//   - a JR target
//   - pc+4
// JAL pushes its return address onto a circular return-address stack (RAS).
// JR pops that stack and reports whether the prediction matched the real target.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   stall          holds pc and the stack, and forces all status pulses low
//   opcode, funct  instruction decode fields (funct is used only for R-type jr)
//   jump_26        J-type target field
//   imm16          branch offset, in words
//   zero           ALU zero flag
//   branch, jump   decode strobes for branches and for J/JAL
//   data1          rs register value, used as the jr target
//   pc             current fetch address (registered)
//   link_addr      pc+4, the jal write-back value
//   flag           redirect kind: 00 beq, 01 bne, 10 j/jal, 11 jr (00 when idle)
//   redirect       combinational; high when the next PC is not pc+4
//   flush          one-cycle pulse in the cycle after an accepted redirect
//   ras_hit        one-cycle pulse: the popped RAS entry equalled the jr target
//   ras_underflow  one-cycle pulse: jr was taken while the RAS was empty
//   misalign       one-cycle pulse: the jr source had non-zero low bits
module next_pc_unit #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       RAS_DEPTH = 4,
    parameter logic [DATA_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic [25:0]       jump_26,
    input  logic [15:0]       imm16,
    input  logic              zero,
    input  logic              branch,
    input  logic              jump,
    input  logic [DATA_W-1:0] data1,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] link_addr,
    output logic [1:0]        flag,
    output logic              redirect,
    output logic              flush,
    output logic              ras_hit,
    output logic              ras_underflow,
    output logic              misalign
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] FLAG_BEQ  = 2'b00;
    localparam logic [1:0] FLAG_BNE  = 2'b01;
    localparam logic [1:0] FLAG_JUMP = 2'b10;
    localparam logic [1:0] FLAG_JR   = 2'b11;

    // Sequential and fetch-path signals.
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] j_target;
    logic [DATA_W-1:0] br_target;
    logic [DATA_W-1:0] jr_target;
    logic [DATA_W-1:0] next_pc;
    logic              is_jr;
    logic              sel_jr;
    logic              sel_jal;

    // Return-address-stack signals.
    logic [DATA_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top;
    logic [PTR_W-1:0]  ras_top_inc;
    logic [PTR_W-1:0]  ras_top_dec;
    logic [CNT_W-1:0]  ras_count;
    logic [DATA_W-1:0] ras_top_val;
    logic              ras_empty;
    logic              ras_full;
    logic              do_push;
    logic              do_pop;

    // Candidate addresses.
    assign pc_plus4  = pc + DATA_W'(4);
    assign link_addr = pc_plus4;
    assign j_target  = {pc_plus4[DATA_W-1:28], jump_26, 2'b00};
    assign br_target = pc_plus4 + {{(DATA_W-18){imm16[15]}}, imm16, 2'b00};
    assign jr_target = {data1[DATA_W-1:2], 2'b00};
    assign is_jr     = (opcode == OP_RTYPE) && (funct == FN_JR);

    // Priority select: a jump strobe shadows any branch or jr decode in the same cycle.
    always_comb begin
        next_pc  = pc_plus4;
        redirect = 1'b0;
        flag     = FLAG_BEQ;
        sel_jr   = 1'b0;
        sel_jal  = 1'b0;
        if (jump) begin
            next_pc  = j_target;
            redirect = 1'b1;
            flag     = FLAG_JUMP;
            sel_jal  = (opcode == OP_JAL);
        end else if (branch && zero && (opcode == OP_BEQ)) begin
            next_pc  = br_target;
            redirect = 1'b1;
            flag     = FLAG_BEQ;
        end else if (branch && !zero && (opcode == OP_BNE)) begin
            next_pc  = br_target;
            redirect = 1'b1;
            flag     = FLAG_BNE;
        end else if (is_jr) begin
            next_pc  = jr_target;
            redirect = 1'b1;
            flag     = FLAG_JR;
            sel_jr   = 1'b1;
        end
    end

    // Circular pointer arithmetic. This also works when RAS_DEPTH is not a power of two.
    assign ras_top_inc = (ras_top == PTR_W'(RAS_DEPTH - 1)) ? '0 : ras_top + PTR_W'(1);
    assign ras_top_dec = (ras_top == '0) ? PTR_W'(RAS_DEPTH - 1) : ras_top - PTR_W'(1);
    assign ras_top_val = ras_mem[ras_top];
    assign ras_empty   = (ras_count == '0);
    assign ras_full    = (ras_count == CNT_W'(RAS_DEPTH));

    assign do_push = sel_jal && !stall && !rst;
    assign do_pop  = sel_jr && !stall && !rst && !ras_empty;

    // Stack storage has no reset: the count alone decides which entries are live.
    // When the stack is full, the slot after the top holds the oldest entry, so a push overwrites it.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ras_top_inc] <= pc_plus4;
        end
    end

    // Fetch pointer, stack bookkeeping and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            ras_top       <= '0;
            ras_count     <= '0;
            flush         <= 1'b0;
            ras_hit       <= 1'b0;
            ras_underflow <= 1'b0;
            misalign      <= 1'b0;
        end else if (stall) begin
            flush         <= 1'b0;
            ras_hit       <= 1'b0;
            ras_underflow <= 1'b0;
            misalign      <= 1'b0;
        end else begin
            pc            <= next_pc;
            flush         <= redirect;
            ras_hit       <= do_pop && (ras_top_val == jr_target);
            ras_underflow <= sel_jr && ras_empty;
            misalign      <= sel_jr && (data1[1:0] != 2'b00);
            if (do_push) begin
                ras_top <= ras_top_inc;
                if (!ras_full) begin
                    ras_count <= ras_count + CNT_W'(1);
                end
            end else if (do_pop) begin
                ras_top   <= ras_top_dec;
                ras_count <= ras_count - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Directed scoreboard bench for next_pc_unit.
// The driver applies one vector per cycle and queues the hand-computed outputs for that cycle.
// A separate monitor samples the outputs on the falling edge and compares them with the queue.
module tb_next_pc_unit;

    localparam logic [5:0] OP_NOP = 6'h23;
    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] FN_JR  = 6'h08;

    typedef struct {
        logic [31:0] pc;
        logic        rd;
        logic [1:0]  flag;
        logic        fl;
        logic        hit;
        logic        uf;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [25:0] jump_26;
    logic [15:0] imm16;
    logic        zero;
    logic        branch;
    logic        jump;
    logic [31:0] data1;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [1:0]  flag;
    logic        redirect;
    logic        flush;
    logic        ras_hit;
    logic        ras_underflow;
    logic        misalign;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    next_pc_unit #(
        .DATA_W   (32),
        .RAS_DEPTH(4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .opcode       (opcode),
        .funct        (funct),
        .jump_26      (jump_26),
        .imm16        (imm16),
        .zero         (zero),
        .branch       (branch),
        .jump         (jump),
        .data1        (data1),
        .pc           (pc),
        .link_addr    (link_addr),
        .flag         (flag),
        .redirect     (redirect),
        .flush        (flush),
        .ras_hit      (ras_hit),
        .ras_underflow(ras_underflow),
        .misalign     (misalign)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: one queued expectation per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc",            pc,                      e.pc);
                chk("link_addr",     link_addr,               e.pc + 32'd4);
                chk("redirect",      32'(redirect),           32'(e.rd));
                chk("flag",          32'(flag),               32'(e.flag));
                chk("flush",         32'(flush),              32'(e.fl));
                chk("ras_hit",       32'(ras_hit),            32'(e.hit));
                chk("ras_underflow", 32'(ras_underflow),      32'(e.uf));
                chk("misalign",      32'(misalign),           32'(e.mis));
            end
        end
    end

    // Drive one cycle of inputs and queue the outputs expected during that cycle.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic [25:0] j26,
                        input logic [15:0] imm, input logic z, input logic br, input logic jp,
                        input logic [31:0] d1, input logic st, input logic rs,
                        input logic [31:0] e_pc, input logic e_rd, input logic [1:0] e_flag,
                        input logic e_fl, input logic e_hit, input logic e_uf, input logic e_mis);
        exp_t e;
        opcode  = op;
        funct   = fn;
        jump_26 = j26;
        imm16   = imm;
        zero    = z;
        branch  = br;
        jump    = jp;
        data1   = d1;
        stall   = st;
        rst     = rs;
        e.pc   = e_pc;
        e.rd   = e_rd;
        e.flag = e_flag;
        e.fl   = e_fl;
        e.hit  = e_hit;
        e.uf   = e_uf;
        e.mis  = e_mis;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; opcode = OP_NOP; funct = '0; jump_26 = '0;
        imm16 = '0; zero = 1'b0; branch = 1'b0; jump = 1'b0; data1 = '0;
        repeat (3) @(posedge clk);
        #1;
        //    op      fn     j26        imm       z  br jp d1             st rs  e_pc           rd fl  fl hit uf mis
        // Reset, then sequential fetch.
        step(OP_NOP, 6'h0, 26'h0,     16'h0,    0, 0, 0, 32'h0,         0, 0, 32'h0000_0000, 0, 0, 0, 0, 0, 0);
        step(OP_NOP, 6'h0, 26'h0,     16'h0,    0, 0, 0, 32'h0,         0, 0, 32'h0000_0004, 0, 0, 0, 0, 0, 0);
        step(OP_NOP, 6'h0, 26'h0,     16'h0,    0, 0, 0, 32'h0,         0, 0, 32'h0000_0008, 0, 0, 0, 0, 0, 0);
        // jr on an empty stack to reach 0x0040_0010.
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h0040_0010, 0, 0, 32'h0000_000C, 1, 3, 0, 0, 0, 0);
        // beq taken backwards: target is 0x0040_0014 - 8.
        step(OP_BEQ, 6'h0, 26'h0,     16'hFFFE, 1, 1, 0, 32'h0,         0, 0, 32'h0040_0010, 1, 0, 1, 0, 1, 0);
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h0040_0010, 0, 0, 32'h0040_000C, 1, 3, 1, 0, 0, 0);
        // beq not taken.
        step(OP_BEQ, 6'h0, 26'h0,     16'hFFFE, 0, 1, 0, 32'h0,         0, 0, 32'h0040_0010, 0, 0, 1, 0, 1, 0);
        // bne taken forward: target is 0x0040_0018 + 12.
        step(OP_BNE, 6'h0, 26'h0,     16'h0003, 0, 1, 0, 32'h0,         0, 0, 32'h0040_0014, 1, 1, 0, 0, 0, 0);
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h1000_0000, 0, 0, 32'h0040_0024, 1, 3, 1, 0, 0, 0);
        // jal, then a jr that returns to the pushed address.
        step(OP_JAL, 6'h0, 26'h40,    16'h0,    0, 0, 1, 32'h0,         0, 0, 32'h1000_0000, 1, 2, 1, 0, 1, 0);
        step(OP_NOP, 6'h0, 26'h0,     16'h0,    0, 0, 0, 32'h0,         0, 0, 32'h1000_0100, 0, 0, 1, 0, 0, 0);
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h1000_0004, 0, 0, 32'h1000_0104, 1, 3, 0, 0, 0, 0);
        // Five jal into a four-entry stack; the first return address is overwritten.
        step(OP_JAL, 6'h0, 26'h100,   16'h0,    0, 0, 1, 32'h0,         0, 0, 32'h1000_0004, 1, 2, 1, 1, 0, 0);
        step(OP_JAL, 6'h0, 26'h200,   16'h0,    0, 0, 1, 32'h0,         0, 0, 32'h1000_0400, 1, 2, 1, 0, 0, 0);
        step(OP_JAL, 6'h0, 26'h300,   16'h0,    0, 0, 1, 32'h0,         0, 0, 32'h1000_0800, 1, 2, 1, 0, 0, 0);
        step(OP_JAL, 6'h0, 26'h400,   16'h0,    0, 0, 1, 32'h0,         0, 0, 32'h1000_0C00, 1, 2, 1, 0, 0, 0);
        step(OP_JAL, 6'h0, 26'h500,   16'h0,    0, 0, 1, 32'h0,         0, 0, 32'h1000_1000, 1, 2, 1, 0, 0, 0);
        // Five jr in LIFO order: four hits, then an underflow.
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h1000_1004, 0, 0, 32'h1000_1400, 1, 3, 1, 0, 0, 0);
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h1000_0C04, 0, 0, 32'h1000_1004, 1, 3, 1, 1, 0, 0);
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h1000_0804, 0, 0, 32'h1000_0C04, 1, 3, 1, 1, 0, 0);
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h1000_0404, 0, 0, 32'h1000_0804, 1, 3, 1, 1, 0, 0);
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h1000_0008, 0, 0, 32'h1000_0404, 1, 3, 1, 1, 0, 0);
        // Misaligned jr source.
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h0000_0103, 0, 0, 32'h1000_0008, 1, 3, 1, 0, 1, 0);
        // Taken beq while stalled: pc holds and no flush follows.
        step(OP_BEQ, 6'h0, 26'h0,     16'h0010, 1, 1, 0, 32'h0,         1, 0, 32'h0000_0100, 1, 0, 1, 0, 1, 1);
        step(OP_NOP, 6'h0, 26'h0,     16'h0,    0, 0, 0, 32'h0,         0, 0, 32'h0000_0100, 0, 0, 0, 0, 0, 0);
        // jal, then reset together with stall: the stack is discarded.
        step(OP_JAL, 6'h0, 26'h80,    16'h0,    0, 0, 1, 32'h0,         0, 0, 32'h0000_0104, 1, 2, 0, 0, 0, 0);
        step(OP_NOP, 6'h0, 26'h0,     16'h0,    0, 0, 0, 32'h0,         1, 1, 32'h0000_0200, 0, 0, 1, 0, 0, 0);
        step(OP_R,   FN_JR, 26'h0,    16'h0,    0, 0, 0, 32'h0000_0108, 0, 0, 32'h0000_0000, 1, 3, 0, 0, 0, 0);
        // jump strobe together with a jr decode: follow the J target and leave the stack alone.
        step(OP_R,   FN_JR, 26'h10,   16'h0,    0, 0, 1, 32'h0000_0108, 0, 0, 32'h0000_0108, 1, 2, 1, 0, 1, 0);
        step(OP_NOP, 6'h0, 26'h0,     16'h0,    0, 0, 0, 32'h0,         0, 0, 32'h0000_0040, 0, 0, 1, 0, 0, 0);
        step(OP_NOP, 6'h0, 26'h0,     16'h0,    0, 0, 0, 32'h0,         0, 0, 32'h0000_0044, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
